// File: rtl/axis_tensor_to_image_descaler.sv
// Float32 tensor stream to uint8 image stream: out = sat(round(x * 255)) per 32-bit lane.
// Two-stage elastic pipeline: stage 1 classifies and multiplies, stage 2 rounds and saturates.
module axis_tensor_to_image_descaler #(
    parameter int unsigned TDATA_WIDTH = 256,
    parameter int unsigned TUSER_WIDTH = 128
) (
    input  logic                     axis_aclk,
    input  logic                     axis_reset,
    input  logic [TDATA_WIDTH-1:0]   axis_tensor_tdata,
    input  logic [TDATA_WIDTH/8-1:0] axis_tensor_tkeep,
    input  logic [TUSER_WIDTH-1:0]   axis_tensor_tuser,
    input  logic                     axis_tensor_tvalid,
    output logic                     axis_tensor_tready,
    input  logic                     axis_tensor_tlast,
    output logic [TDATA_WIDTH/4-1:0] axis_image_tdata,
    output logic [TDATA_WIDTH/32-1:0] axis_image_tkeep,
    output logic [TUSER_WIDTH-1:0]   axis_image_tuser,
    output logic                     axis_image_tvalid,
    input  logic                     axis_image_tready,
    output logic                     axis_image_tlast
);

    localparam int unsigned LANES = TDATA_WIDTH / 32;

    logic                        s1_valid;
    logic [LANES-1:0]            s1_zero;
    logic [LANES-1:0]            s1_sat;
    logic [LANES-1:0]            s1_keep;
    logic [LANES-1:0][31:0]      s1_prod;
    logic [LANES-1:0][5:0]       s1_sh;
    logic [TUSER_WIDTH-1:0]      s1_tuser;
    logic                        s1_tlast;

    logic [LANES-1:0]            conv_zero;
    logic [LANES-1:0]            conv_sat;
    logic [LANES-1:0]            conv_keep;
    logic [LANES-1:0][31:0]      conv_prod;
    logic [LANES-1:0][5:0]       conv_sh;
    logic [31:0]                 lane;
    logic [7:0]                  lane_shift;

    logic [LANES-1:0][7:0]       px;
    logic [32:0]                 rnd_sum;
    logic [32:0]                 rnd_shr;

    logic                        s2_ready;
    logic                        in_fire;
    logic                        unused_tkeep_bits;

    // Only tkeep[4i] qualifies a lane; the other byte enables are don't-care.
    assign unused_tkeep_bits = ^axis_tensor_tkeep;

    assign s2_ready           = !axis_image_tvalid || axis_image_tready;
    assign axis_tensor_tready = !axis_reset && (!s1_valid || s2_ready);
    assign in_fire            = axis_tensor_tvalid && axis_tensor_tready;

    always_comb begin
        conv_zero  = '0;
        conv_sat   = '0;
        conv_keep  = '0;
        conv_prod  = '0;
        conv_sh    = '0;
        lane       = '0;
        lane_shift = '0;
        for (int i = 0; i < LANES; i++) begin
            lane       = axis_tensor_tdata[32*i +: 32];
            lane_shift = 8'd150 - lane[30:23];
            // Negative, NaN, zero/denormal, and values whose rounded result is below one LSB.
            conv_zero[i] = lane[31] || (lane[30:23] == 8'h00)
                         || ((lane[30:23] == 8'hFF) && (lane[22:0] != 23'd0))
                         || ((lane[30:23] < 8'd127) && (lane_shift > 8'd32));
            conv_sat[i]  = !conv_zero[i] && (lane[30:23] >= 8'd127);
            conv_prod[i] = 32'({1'b1, lane[22:0]}) * 32'd255;
            conv_sh[i]   = lane_shift[5:0];
            conv_keep[i] = axis_tensor_tkeep[4*i];
        end
    end

    always_comb begin
        px      = '0;
        rnd_sum = '0;
        rnd_shr = '0;
        for (int i = 0; i < LANES; i++) begin
            // 33-bit sum: the half-LSB addend for a 32-bit shift can carry out of P.
            rnd_sum = {1'b0, s1_prod[i]} + (33'd1 << (s1_sh[i] - 6'd1));
            rnd_shr = rnd_sum >> s1_sh[i];
            if (!s1_keep[i] || s1_zero[i]) begin
                px[i] = 8'h00;
            end else if (s1_sat[i] || (rnd_shr > 33'd255)) begin
                px[i] = 8'hFF;
            end else begin
                px[i] = rnd_shr[7:0];
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            s1_valid <= 1'b0;
            s1_zero  <= '0;
            s1_sat   <= '0;
            s1_keep  <= '0;
            s1_prod  <= '0;
            s1_sh    <= '0;
            s1_tuser <= '0;
            s1_tlast <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_zero  <= conv_zero;
            s1_sat   <= conv_sat;
            s1_keep  <= conv_keep;
            s1_prod  <= conv_prod;
            s1_sh    <= conv_sh;
            s1_tuser <= axis_tensor_tuser;
            s1_tlast <= axis_tensor_tlast;
        end else if (s1_valid && s2_ready) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            axis_image_tvalid <= 1'b0;
            axis_image_tdata  <= '0;
            axis_image_tkeep  <= '0;
            axis_image_tuser  <= '0;
            axis_image_tlast  <= 1'b0;
        end else if (s2_ready) begin
            axis_image_tvalid <= s1_valid;
            if (s1_valid) begin
                axis_image_tdata <= px;
                axis_image_tkeep <= s1_keep;
                axis_image_tuser <= s1_tuser;
                axis_image_tlast <= s1_tlast;
            end
        end
    end

endmodule

// File: tb/tb_axis_tensor_to_image_descaler.sv
// Self-checking bench for axis_tensor_to_image_descaler: vector tables, hand-written
// corner sequences and a randomized stream scored against a real-arithmetic model.
module tb_axis_tensor_to_image_descaler;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] t_tdata;
    logic [31:0]  t_tkeep;
    logic [127:0] t_tuser;
    logic         t_tvalid;
    logic         t_tready;
    logic         t_tlast;
    logic [63:0]  i_tdata;
    logic [7:0]   i_tkeep;
    logic [127:0] i_tuser;
    logic         i_tvalid;
    logic         i_tready;
    logic         i_tlast;

    int checks = 0;
    int errors = 0;
    int out_count = 0;
    logic [200:0] exp_q[$];

    typedef struct {
        logic [31:0] x;
        logic [7:0]  px;
    } conv_vec_t;

    typedef struct {
        logic [31:0] k;
        logic [63:0] d;
        logic [7:0]  kb;
    } keep_vec_t;

    always #5 clk = ~clk;

    axis_tensor_to_image_descaler #(
        .TDATA_WIDTH(256),
        .TUSER_WIDTH(128)
    ) dut (
        .axis_aclk          (clk),
        .axis_reset         (rst),
        .axis_tensor_tdata  (t_tdata),
        .axis_tensor_tkeep  (t_tkeep),
        .axis_tensor_tuser  (t_tuser),
        .axis_tensor_tvalid (t_tvalid),
        .axis_tensor_tready (t_tready),
        .axis_tensor_tlast  (t_tlast),
        .axis_image_tdata   (i_tdata),
        .axis_image_tkeep   (i_tkeep),
        .axis_image_tuser   (i_tuser),
        .axis_image_tvalid  (i_tvalid),
        .axis_image_tready  (i_tready),
        .axis_image_tlast   (i_tlast)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference pixel: widen float32 to a real, scale, round half up, clamp.
    function automatic logic [7:0] ref_px(input logic [31:0] f);
        logic [63:0] dbits;
        real         y;
        int          e;
        e = int'(f[30:23]);
        if (f[31] || e == 0) return 8'h00;
        if (e == 255) return (f[22:0] == 23'd0) ? 8'hFF : 8'h00;
        dbits = {1'b0, 11'(e + 896), f[22:0], 29'd0};
        y = $bitstoreal(dbits) * 255.0;
        if (y >= 255.0) return 8'hFF;
        return 8'($rtoi(y + 0.5));
    endfunction

    function automatic logic [200:0] model_out(input logic [255:0] d, input logic [31:0] k,
                                               input logic [127:0] u, input logic l);
        logic [63:0] p;
        logic [7:0]  kb;
        p  = '0;
        kb = '0;
        for (int i = 0; i < 8; i++) begin
            kb[i]      = k[4*i];
            p[8*i +: 8] = k[4*i] ? ref_px(d[32*i +: 32]) : 8'h00;
        end
        return {p, kb, u, l};
    endfunction

    function automatic logic [31:0] rand_lane();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[30:23] = 8'hFF;
            1: r[30:23] = 8'h00;
            default: begin
                r[31]    = ($urandom_range(0, 7) == 0);
                r[30:23] = 8'($urandom_range(112, 128));
            end
        endcase
        return r;
    endfunction

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = rand_lane();
        return d;
    endfunction

    // Monitor: sampled mid-cycle, between the edges where inputs change and handshakes occur.
    initial begin
        logic         held;
        logic [200:0] held_v;
        logic [200:0] cur;
        held   = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            cur = {i_tdata, i_tkeep, i_tuser, i_tlast};
            if (rst) begin
                exp_q.delete();
                held = 1'b0;
            end else begin
                if (held) chk("stall_hold", 256'({i_tvalid, cur}), 256'({1'b1, held_v}));
                if (t_tvalid && t_tready)
                    exp_q.push_back(model_out(t_tdata, t_tkeep, t_tuser, t_tlast));
                if (i_tvalid && i_tready) begin
                    out_count++;
                    chk("out_expected_present", 256'(exp_q.size() != 0), 256'(1));
                    if (exp_q.size() != 0) chk("out_beat", 256'(cur), 256'(exp_q.pop_front()));
                end
                held   = i_tvalid && !i_tready;
                held_v = cur;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k,
                             input logic [127:0] u, input logic l);
        int t;
        t_tdata  = d;
        t_tkeep  = k;
        t_tuser  = u;
        t_tlast  = l;
        t_tvalid = 1'b1;
        #1;
        t = 0;
        while (!t_tready && t < 200) begin
            step();
            t++;
        end
        if (!t_tready) chk("send_timeout", 256'(t_tready), 256'(1));
        step();
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!i_tvalid && n < 20) begin
            step();
            n++;
        end
        if (!i_tvalid) chk("valid_timeout", 256'(i_tvalid), 256'(1));
    endtask

    task automatic drain();
        t_tvalid = 1'b0;
        i_tready = 1'b1;
        repeat (5) step();
    endtask

    initial begin
        conv_vec_t cv[18];
        keep_vec_t kv[3];
        int        n, acc, bad, base, cyc, sent;
        logic      hs, have, expv;

        cv[0]  = '{32'h00000000, 8'h00};
        cv[1]  = '{32'h3F800000, 8'hFF};
        cv[2]  = '{32'h3F000000, 8'h80};
        cv[3]  = '{32'h3B808081, 8'h01};
        cv[4]  = '{32'hBF000000, 8'h00};
        cv[5]  = '{32'h7F800000, 8'hFF};
        cv[6]  = '{32'h7FC00000, 8'h00};
        cv[7]  = '{32'h40000000, 8'hFF};
        cv[8]  = '{32'h3AFFFFFF, 8'h00};
        cv[9]  = '{32'h3B7FFFFF, 8'h01};
        cv[10] = '{32'h3F7FFFFF, 8'hFF};
        cv[11] = '{32'h3E800000, 8'h40};
        cv[12] = '{32'h00400000, 8'h00};
        cv[13] = '{32'h80000000, 8'h00};
        cv[14] = '{32'hFF800000, 8'h00};
        cv[15] = '{32'h7F800001, 8'h00};
        cv[16] = '{32'h3F400000, 8'hBF};
        cv[17] = '{32'h3C000000, 8'h02};
        kv[0]  = '{32'h0000FFFF, 64'h00000000FFFFFFFF, 8'h0F};
        kv[1]  = '{32'hEEEEEEEE, 64'h0000000000000000, 8'h00};
        kv[2]  = '{32'h11111111, 64'hFFFFFFFFFFFFFFFF, 8'hFF};

        rst      = 1'b1;
        t_tvalid = 1'b0;
        t_tdata  = '0;
        t_tkeep  = '0;
        t_tuser  = '0;
        t_tlast  = 1'b0;
        i_tready = 1'b0;
        repeat (3) step();
        chk("reset_tvalid", 256'(i_tvalid), 256'(0));
        chk("reset_outputs", 256'({i_tdata, i_tkeep, i_tuser, i_tlast}), 256'(0));
        chk("reset_tready", 256'(t_tready), 256'(0));
        rst = 1'b0;
        #1;
        chk("post_reset_tready", 256'(t_tready), 256'(1));

        // Conversion vectors, one beat each with the value in every lane.
        i_tready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            send_beat({8{cv[i].x}}, 32'hFFFFFFFF, 128'(i), i[0]);
            t_tvalid = 1'b0;
            wait_valid(n);
            chk($sformatf("conv_%08h", cv[i].x), 256'(i_tdata), 256'({8{cv[i].px}}));
            if (i == 0) chk("latency_first", 256'(n), 256'(2));
        end

        // Lane qualification by tkeep[4i] only.
        for (int i = 0; i < 3; i++) begin
            send_beat({8{32'h3F800000}}, kv[i].k, 128'(i), 1'b0);
            t_tvalid = 1'b0;
            wait_valid(n);
            chk($sformatf("keep_data_%08h", kv[i].k), 256'(i_tdata), 256'(kv[i].d));
            chk($sformatf("keep_bits_%08h", kv[i].k), 256'(i_tkeep), 256'(kv[i].kb));
        end
        drain();

        // 64 back-to-back beats with downstream always ready.
        acc  = 0;
        bad  = 0;
        base = out_count;
        for (int c = 0; c < 70; c++) begin
            expv = (c >= 2 && c <= 65);
            if (i_tvalid !== expv) bad++;
            if (c < 64) begin
                t_tdata  = rand_data();
                t_tkeep  = 32'hFFFFFFFF;
                t_tuser  = {$urandom, $urandom, $urandom, $urandom};
                t_tlast  = (c == 63);
                t_tvalid = 1'b1;
            end else begin
                t_tvalid = 1'b0;
            end
            #1;
            if (t_tvalid && t_tready) acc++;
            step();
        end
        chk("b2b_accepted", 256'(acc), 256'(64));
        chk("b2b_valid_pattern_errors", 256'(bad), 256'(0));
        chk("b2b_outputs", 256'(out_count - base), 256'(64));
        drain();

        // Randomized valid/ready on a 200-beat stream.
        base = out_count;
        sent = 0;
        cyc  = 0;
        have = 1'b0;
        while (cyc < 5000 && (sent < 200 || exp_q.size() != 0)) begin
            if (!have && sent < 200 && $urandom_range(0, 9) < 7) begin
                t_tdata = rand_data();
                t_tkeep = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'hFFFFFFFF;
                t_tuser = {$urandom, $urandom, $urandom, $urandom};
                t_tlast = 1'($urandom_range(0, 1));
                have    = 1'b1;
            end
            t_tvalid = have;
            i_tready = ($urandom_range(0, 9) < 6);
            #1;
            hs = have && t_tready;
            step();
            if (hs) begin
                have = 1'b0;
                sent++;
            end
            cyc++;
        end
        chk("rand_sent", 256'(sent), 256'(200));
        chk("rand_outputs", 256'(out_count - base), 256'(200));
        chk("rand_queue_empty", 256'(exp_q.size()), 256'(0));
        drain();

        // Backpressure: two beats fill the pipeline, the third waits.
        i_tready = 1'b0;
        base     = out_count;
        acc      = 0;
        for (int k = 0; k < 3; k++) begin
            t_tdata  = rand_data();
            t_tkeep  = 32'hFFFFFFFF;
            t_tuser  = 128'(k + 100);
            t_tlast  = (k == 2);
            t_tvalid = 1'b1;
            #1;
            hs = t_tready;
            step();
            if (hs) acc++;
            if (!hs) break;
        end
        chk("bp_accepted", 256'(acc), 256'(2));
        repeat (3) step();
        chk("bp_tready_low", 256'(t_tready), 256'(0));
        chk("bp_output_held", 256'(i_tvalid), 256'(1));
        i_tready = 1'b1;
        #1;
        n = 0;
        while (!t_tready && n < 50) begin
            step();
            n++;
        end
        step();
        t_tvalid = 1'b0;
        repeat (6) step();
        chk("bp_emitted", 256'(out_count - base), 256'(3));

        // Reset with two beats in flight.
        i_tready = 1'b0;
        send_beat(rand_data(), 32'hFFFFFFFF, 128'h1, 1'b0);
        send_beat(rand_data(), 32'hFFFFFFFF, 128'h2, 1'b1);
        t_tvalid = 1'b0;
        step();
        chk("inflight_valid", 256'(i_tvalid), 256'(1));
        rst = 1'b1;
        step();
        chk("midreset_tvalid", 256'(i_tvalid), 256'(0));
        chk("midreset_outputs", 256'({i_tdata, i_tkeep, i_tuser, i_tlast}), 256'(0));
        chk("midreset_tready", 256'(t_tready), 256'(0));
        rst      = 1'b0;
        i_tready = 1'b1;
        base     = out_count;
        send_beat({8{32'h3F000000}}, 32'hFFFFFFFF, 128'hABCD, 1'b1);
        t_tvalid = 1'b0;
        wait_valid(n);
        chk("post_reset_latency", 256'(n), 256'(2));
        chk("post_reset_data", 256'(i_tdata), 256'({8{8'h80}}));
        chk("post_reset_tuser_tlast", 256'({i_tuser, i_tlast}), 256'({128'hABCD, 1'b1}));
        repeat (4) step();
        chk("post_reset_count", 256'(out_count - base), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
